// File: rtl/serial_crc_pkg.sv
// Shared definitions for the bit-serial CRC unit.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package serial_crc_pkg;

  // Frame control states; encodings are fixed so they can be probed externally.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Default generator polynomial, CRC-8 (x^8 + x^2 + x + 1) without the x^8 term.
  localparam logic [7:0] CRC8_POLY = 8'h07;

endpackage

// File: rtl/crc_bit_step.sv
// One MSB-first CRC step: the XOR feedback network for a single message bit.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is registered.
module crc_bit_step
  import serial_crc_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC8_POLY)
) (
  input  logic [WIDTH-1:0] crc_in,
  input  logic             bit_in,
  output logic [WIDTH-1:0] crc_next
);

  logic fb;

  // Feedback is the outgoing MSB mixed with the new message bit; it gates the taps.
  always_comb begin
    fb       = crc_in[WIDTH-1] ^ bit_in;
    crc_next = (crc_in << 1) ^ (fb ? POLY : '0);
  end

endmodule

// File: rtl/serial_crc_unit.sv
// Bit-serial CRC over a fixed-length frame, result offered on a valid/ack handshake.
// Latency: one bit per accepted cycle; crc_valid rises the cycle after the last bit.
// Backpressure: bit_valid low stalls SHIFT indefinitely; HOLD waits for crc_ack.
module serial_crc_unit
  import serial_crc_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] POLY       = WIDTH'(CRC8_POLY),
  parameter logic [WIDTH-1:0] INIT       = '0,
  parameter int               FRAME_BITS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [WIDTH-1:0] crc_out,
  output logic             crc_valid,
  input  logic             crc_ack,
  output logic             busy,
  output logic [7:0]       bit_count
);

  // Count value held just before the final bit is accepted.
  localparam logic [7:0] LAST_IDX = 8'(FRAME_BITS - 1);

  state_t           state;
  state_t           state_next;
  logic             load_init;
  logic             accept;
  logic [WIDTH-1:0] crc_q;
  logic [WIDTH-1:0] crc_step;
  logic [7:0]       count_q;

  crc_bit_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .crc_in   (crc_q),
    .bit_in   (bit_in),
    .crc_next (crc_step)
  );

  // State register; reset discards any partial frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the two datapath strobes (reload and accept).
  always_comb begin
    state_next = state;
    load_init  = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load_init  = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A restart takes priority over a bit presented in the same cycle.
        if (start) begin
          load_init = 1'b1;
        end else if (bit_valid) begin
          accept = 1'b1;
          if (count_q == LAST_IDX) begin
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Start alone is ignored here so the pending result cannot be lost.
        if (crc_ack) begin
          if (start) begin
            load_init  = 1'b1;
            state_next = ST_SHIFT;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // CRC register and bit counter: reload on start, advance on each accepted bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc_q   <= '0;
      count_q <= 8'd0;
    end else if (load_init) begin
      crc_q   <= INIT;
      count_q <= 8'd0;
    end else if (accept) begin
      crc_q   <= crc_step;
      count_q <= count_q + 8'd1;
    end
  end

  // Handshake outputs decode from the state register only, never from inputs.
  always_comb begin
    bit_ready = (state == ST_SHIFT);
    busy      = (state == ST_SHIFT);
    crc_valid = (state == ST_HOLD);
    crc_out   = crc_q;
    bit_count = count_q;
  end

endmodule

// File: tb/tb_serial_crc_unit.sv
// Self-checking bench: two instances (8-bit and 16-bit frames) share the stimulus.
// Latency: n/a.
// Backpressure: exercised through bit_valid stalls and delayed crc_ack.
module tb_serial_crc_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic crc_ack = 1'b0;

  logic       bit_ready_a, crc_valid_a, busy_a;
  logic [7:0] crc_out_a, bit_count_a;
  logic       bit_ready_b, crc_valid_b, busy_b;
  logic [7:0] crc_out_b, bit_count_b;

  logic       sel16 = 1'b0;
  logic       bit_ready, crc_valid, busy;
  logic [7:0] crc_out, bit_count;
  int         frame_bits;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  serial_crc_unit #(.WIDTH(8), .POLY(8'h07), .INIT(8'h00), .FRAME_BITS(8)) dut8 (
    .clock(clock), .reset(reset), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_a), .crc_out(crc_out_a), .crc_valid(crc_valid_a), .crc_ack(crc_ack),
    .busy(busy_a), .bit_count(bit_count_a)
  );

  serial_crc_unit #(.WIDTH(8), .POLY(8'h07), .INIT(8'h00), .FRAME_BITS(16)) dut16 (
    .clock(clock), .reset(reset), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_b), .crc_out(crc_out_b), .crc_valid(crc_valid_b), .crc_ack(crc_ack),
    .busy(busy_b), .bit_count(bit_count_b)
  );

  always #5 clock = ~clock;

  always_comb begin
    bit_ready  = sel16 ? bit_ready_b : bit_ready_a;
    crc_valid  = sel16 ? crc_valid_b : crc_valid_a;
    busy       = sel16 ? busy_b      : busy_a;
    crc_out    = sel16 ? crc_out_b   : crc_out_a;
    bit_count  = sel16 ? bit_count_b : bit_count_a;
    frame_bits = sel16 ? 16 : 8;
  end

  function automatic logic [7:0] crc8_model(input logic [15:0] data, input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      fb = c[7] ^ data[n-1-i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0; bit_valid = 1'b0; crc_ack = 1'b0; bit_in = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || bit_ready !== 1'b1) begin
      bad++; $display("FAIL start_busy: busy=%b bit_ready=%b want 1/1", busy, bit_ready);
    end
    total++;
    if (bit_count !== 8'd0 || crc_out !== 8'h00) begin
      bad++; $display("FAIL start_init: bit_count=%0d crc_out=%h want 0/00", bit_count, crc_out);
    end
  endtask

  task automatic send_bits(input logic [15:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      bit_in = data[n-1-i];
      bit_valid = 1'b1;
      tick();
      total++;
      if (bit_count !== 8'(i + 1)) begin
        bad++; $display("FAIL send_count: bit %0d bit_count=%0d want %0d", i, bit_count, i + 1);
      end
      total++;
      if (crc_valid !== ((i + 1) == frame_bits)) begin
        bad++; $display("FAIL send_valid: bit %0d crc_valid=%b want %b", i, crc_valid, (i + 1) == frame_bits);
      end
    end
    bit_valid = 1'b0;
    bit_in = 1'b0;
  endtask

  task automatic get_result();
    int n;
    logic [7:0] exp;
    n = 0;
    while (crc_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (crc_valid !== 1'b1) begin
      bad++; $display("FAIL result_timeout: crc_valid=%b want 1 within 40 cycles", crc_valid);
    end else if (exp_q.size() == 0) begin
      bad++; $display("FAIL result_unexpected: crc_out=%h with empty scoreboard", crc_out);
    end else begin
      exp = exp_q.pop_front();
      if (crc_out !== exp || bit_count !== 8'(frame_bits) || busy !== 1'b0) begin
        bad++;
        $display("FAIL result: crc_out=%h bit_count=%0d busy=%b want %h/%0d/0",
                 crc_out, bit_count, busy, exp, frame_bits);
      end
    end
  endtask

  task automatic ack_result();
    crc_ack = 1'b1;
    tick();
    crc_ack = 1'b0;
    total++;
    if (crc_valid !== 1'b0 || busy !== 1'b0 || bit_ready !== 1'b0) begin
      bad++; $display("FAIL ack_idle: crc_valid=%b busy=%b bit_ready=%b want 0/0/0", crc_valid, busy, bit_ready);
    end
  endtask

  task automatic test_reset();
    sel16 = 1'b0;
    do_reset();
    total++;
    if ({bit_ready_a, crc_valid_a, busy_a, crc_out_a, bit_count_a} !== 19'd0 ||
        {bit_ready_b, crc_valid_b, busy_b, crc_out_b, bit_count_b} !== 19'd0) begin
      bad++; $display("FAIL reset_state: dut8 crc=%h cnt=%0d dut16 crc=%h cnt=%0d want all zero",
                      crc_out_a, bit_count_a, crc_out_b, bit_count_b);
    end
  endtask

  task automatic test_single_frame();
    sel16 = 1'b0;
    do_reset();
    start_frame();
    exp_q.push_back(8'h07);
    send_bits(16'h0001, 8);
    get_result();
    ack_result();
  endtask

  task automatic test_back_to_back();
    sel16 = 1'b0;
    do_reset();
    start_frame();
    exp_q.push_back(8'h89);
    send_bits(16'h0080, 8);
    get_result();
    ack_result();
    start_frame();
    exp_q.push_back(8'hF3);
    send_bits(16'h00FF, 8);
    get_result();
    ack_result();
  endtask

  task automatic test_stall();
    sel16 = 1'b1;
    do_reset();
    start_frame();
    exp_q.push_back(8'h00);
    for (int i = 0; i < 16; i++) begin
      bit_in = 1'b0;
      bit_valid = 1'b0;
      tick();
      total++;
      if (bit_count !== 8'(i) || busy !== 1'b1) begin
        bad++; $display("FAIL stall_hold: cycle %0d bit_count=%0d busy=%b want %0d/1", i, bit_count, busy, i);
      end
      bit_valid = 1'b1;
      tick();
      total++;
      if (bit_count !== 8'(i + 1)) begin
        bad++; $display("FAIL stall_accept: bit %0d bit_count=%0d want %0d", i, bit_count, i + 1);
      end
    end
    bit_valid = 1'b0;
    get_result();
    ack_result();
    start_frame();
    exp_q.push_back(crc8_model(16'hA5C3, 16));
    send_bits(16'hA5C3, 16);
    get_result();
    ack_result();
  endtask

  task automatic test_abort();
    sel16 = 1'b0;
    do_reset();
    start_frame();
    send_bits(16'h001F, 5);
    start = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    tick();
    start = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    total++;
    if (bit_count !== 8'd0 || crc_out !== 8'h00 || busy !== 1'b1) begin
      bad++; $display("FAIL abort_reload: bit_count=%0d crc_out=%h busy=%b want 0/00/1", bit_count, crc_out, busy);
    end
    exp_q.push_back(8'h07);
    send_bits(16'h0001, 8);
    get_result();
    ack_result();
  endtask

  task automatic test_async_reset();
    sel16 = 1'b0;
    do_reset();
    start_frame();
    send_bits(16'h0007, 3);
    #3 reset = 1'b1;
    #1;
    total++;
    if ({bit_ready, crc_valid, busy, crc_out, bit_count} !== 19'd0) begin
      bad++; $display("FAIL async_reset_shift: rdy=%b vld=%b busy=%b crc=%h cnt=%0d want all zero",
                      bit_ready, crc_valid, busy, crc_out, bit_count);
    end
    tick();
    reset = 1'b0;
    start_frame();
    exp_q.push_back(8'h07);
    send_bits(16'h0001, 8);
    get_result();
    #3 reset = 1'b1;
    #1;
    total++;
    if ({bit_ready, crc_valid, busy, crc_out, bit_count} !== 19'd0) begin
      bad++; $display("FAIL async_reset_hold: rdy=%b vld=%b busy=%b crc=%h cnt=%0d want all zero",
                      bit_ready, crc_valid, busy, crc_out, bit_count);
    end
    tick();
    reset = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || crc_valid !== 1'b0) begin
      bad++; $display("FAIL reset_idle: busy=%b crc_valid=%b want 0/0", busy, crc_valid);
    end
    start_frame();
    exp_q.push_back(8'h89);
    send_bits(16'h0080, 8);
    get_result();
    ack_result();
  endtask

  task automatic test_hold();
    sel16 = 1'b0;
    do_reset();
    start_frame();
    exp_q.push_back(8'h89);
    send_bits(16'h0080, 8);
    get_result();
    for (int i = 0; i < 10; i++) begin
      start = (i % 2 == 0);
      tick();
      total++;
      if (crc_valid !== 1'b1 || crc_out !== 8'h89 || bit_count !== 8'd8) begin
        bad++; $display("FAIL hold_stable: cycle %0d vld=%b crc=%h cnt=%0d want 1/89/8", i, crc_valid, crc_out, bit_count);
      end
    end
    start = 1'b1;
    crc_ack = 1'b1;
    tick();
    start = 1'b0;
    crc_ack = 1'b0;
    total++;
    if (busy !== 1'b1 || bit_count !== 8'd0 || crc_valid !== 1'b0 || crc_out !== 8'h00) begin
      bad++; $display("FAIL hold_restart: busy=%b cnt=%0d vld=%b crc=%h want 1/0/0/00", busy, bit_count, crc_valid, crc_out);
    end
    exp_q.push_back(8'hF3);
    send_bits(16'h00FF, 8);
    get_result();
    ack_result();
    crc_ack = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (busy !== 1'b0 || crc_valid !== 1'b0 || bit_ready !== 1'b0 || crc_out !== 8'hF3) begin
        bad++; $display("FAIL idle_ignore: busy=%b vld=%b rdy=%b crc=%h want 0/0/0/f3", busy, crc_valid, bit_ready, crc_out);
      end
    end
    crc_ack = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_abort();
    test_async_reset();
    test_hold();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: %0d results still expected, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
